// File: rtl/decoder_mode_sequencer_if.sv
// decoder_mode_sequencer_if
//   Bundles the configuration handshake and the level/topology path between
//   a modulator-side controller (master) and the mode sequencer (slave).
//   master: drives cfg_* request fields and v_lev_in, observes status.
//   slave : accepts requests, drives v_lev_out/npc_type_out/comm_type_out,
//           busy, done and fault.
interface decoder_mode_sequencer_if #(
  parameter int TDELAY_WIDTH = 16
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [1:0]              cfg_npc_type;
  logic [1:0]              cfg_comm_type;
  logic [TDELAY_WIDTH-1:0] cfg_t_blank;
  logic [1:0]              v_lev_in;
  logic [1:0]              v_lev_out;
  logic [1:0]              npc_type_out;
  logic [1:0]              comm_type_out;
  logic                    busy;
  logic                    done;
  logic                    fault;

  modport master (
    output cfg_valid, cfg_npc_type, cfg_comm_type, cfg_t_blank, v_lev_in,
    input  cfg_ready, v_lev_out, npc_type_out, comm_type_out, busy, done, fault
  );

  modport slave (
    input  cfg_valid, cfg_npc_type, cfg_comm_type, cfg_t_blank, v_lev_in,
    output cfg_ready, v_lev_out, npc_type_out, comm_type_out, busy, done, fault
  );
endinterface

// File: rtl/decoder_mode_sequencer.sv
// decoder_mode_sequencer
//   Safely switches the decoder between converter topologies. A new
//   configuration is brought in through three equal hold phases: outputs
//   forced to zero level (ZERO_HOLD), topology switched off (BLANK), then
//   the new topology/commutation applied while still at zero (APPLY).
//   In RUN the level command is passed through with one register stage.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decoder_mode_sequencer_if.slave
//              cfg_valid/cfg_ready handshake with cfg_npc_type,
//              cfg_comm_type, cfg_t_blank; v_lev_in -> v_lev_out;
//              npc_type_out, comm_type_out, busy, done, fault.
module decoder_mode_sequencer #(
  parameter int TDELAY_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  decoder_mode_sequencer_if.slave       bus
);

  typedef enum logic [2:0] {IDLE, RUN, ZERO_HOLD, BLANK, APPLY} state_t;

  localparam logic [1:0] LEV_ZERO = 2'd1;
  localparam logic [1:0] LEV_BAD  = 2'd3;
  localparam logic [1:0] NO_OUT   = 2'd0;

  state_t                  state;
  logic [TDELAY_WIDTH-1:0] cnt;
  logic [TDELAY_WIDTH-1:0] t_lat;
  logic [1:0]              npc_lat;
  logic [1:0]              comm_lat;

  logic                    accept;
  logic                    same_cfg;
  logic [TDELAY_WIDTH-1:0] hold_in;
  logic [TDELAY_WIDTH-1:0] hold_lat;

  assign bus.cfg_ready = (state == IDLE) || (state == RUN);
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign same_cfg      = (bus.cfg_npc_type == bus.npc_type_out) &&
                         (bus.cfg_comm_type == bus.comm_type_out);

  // Counter reload is max(t,1)-1, so t=0 behaves as 1 and the all-ones
  // value never wraps: each phase lasts max(t,1) cycles.
  assign hold_in  = (bus.cfg_t_blank == '0) ? '0 : bus.cfg_t_blank - TDELAY_WIDTH'(1);
  assign hold_lat = (t_lat == '0) ? '0 : t_lat - TDELAY_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      t_lat             <= '0;
      npc_lat           <= NO_OUT;
      comm_lat          <= 2'd0;
      bus.v_lev_out     <= LEV_ZERO;
      bus.npc_type_out  <= NO_OUT;
      bus.comm_type_out <= 2'd0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.fault         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (state == RUN) begin
            // Invalid level is never forwarded to the decoder.
            if (bus.v_lev_in == LEV_BAD) begin
              bus.v_lev_out <= LEV_ZERO;
              bus.fault     <= 1'b1;
            end else begin
              bus.v_lev_out <= bus.v_lev_in;
            end
          end
          if (accept) begin
            npc_lat  <= bus.cfg_npc_type;
            comm_lat <= bus.cfg_comm_type;
            t_lat    <= bus.cfg_t_blank;
            if (same_cfg) begin
              bus.done <= 1'b1;
            end else begin
              state         <= ZERO_HOLD;
              cnt           <= hold_in;
              bus.busy      <= 1'b1;
              bus.v_lev_out <= LEV_ZERO;
            end
          end
        end
        ZERO_HOLD: begin
          if (cnt == '0) begin
            state            <= BLANK;
            cnt              <= hold_lat;
            bus.npc_type_out <= NO_OUT;
          end else begin
            cnt <= cnt - TDELAY_WIDTH'(1);
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state             <= APPLY;
            cnt               <= hold_lat;
            bus.npc_type_out  <= npc_lat;
            bus.comm_type_out <= comm_lat;
          end else begin
            cnt <= cnt - TDELAY_WIDTH'(1);
          end
        end
        APPLY: begin
          if (cnt == '0) begin
            state    <= (npc_lat == NO_OUT) ? IDLE : RUN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            cnt <= cnt - TDELAY_WIDTH'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/decoder_mode_sequencer.md
DECODER_MODE_SEQUENCER -- requirements
Module: decoder_mode_sequencer

Interface
REQ-001 Parameter TDELAY_WIDTH, default 16, width of the blanking-time count.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cfg_valid  input  1  new-configuration request.
REQ-005 cfg_ready  output  1  sequencer can accept a request.
REQ-006 cfg_npc_type  input  2  requested topology: 0 NoOut, 1 NPC, 2 NPP, 3 ANPC.
REQ-007 cfg_comm_type  input  2  requested ANPC commutation type.
REQ-008 cfg_t_blank  input  TDELAY_WIDTH  blanking hold time, in clk cycles.
REQ-009 v_lev_in  input  2  level command from the modulator: 0 negative, 1 zero, 2 positive, 3 invalid.
REQ-010 v_lev_out  output  2  level command driven to the decoder.
REQ-011 npc_type_out  output  2  topology select driven to the decoder.
REQ-012 comm_type_out  output  2  commutation type driven to the decoder.
REQ-013 busy  output  1  reconfiguration sequence in progress.
REQ-014 done  output  1  one-cycle pulse when the new configuration is live.
REQ-015 fault  output  1  sticky flag set when v_lev_in == 3 is seen.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, ZERO_HOLD, BLANK and APPLY.
REQ-017 cfg_ready SHALL be 1 only in IDLE and RUN.
REQ-018 A request SHALL be accepted on the cycle where cfg_valid & cfg_ready is true.
  - On acceptance, cfg_npc_type, cfg_comm_type and cfg_t_blank SHALL be latched.
  - Request inputs SHALL be ignored while cfg_ready is 0.
REQ-019 Accept in RUN or IDLE, when the latched config differs from the current (npc_type_out, comm_type_out):
  - The next state SHALL be ZERO_HOLD.
  - The counter SHALL load max(cfg_t_blank, 1) - 1.
REQ-020 Accept in RUN when the config is identical to the current one:
  - The FSM SHALL stay in RUN.
  - done SHALL pulse on the next cycle.
  - No blanking SHALL occur.
REQ-021 ZERO_HOLD: v_lev_out = 1 (zero) and npc_type_out unchanged.
  - The counter SHALL decrement each cycle.
  - At count 0 the FSM SHALL go to BLANK and reload the counter.
REQ-022 BLANK: npc_type_out = NoOut and v_lev_out = 1.
  - The counter SHALL count down.
  - At count 0 the FSM SHALL go to APPLY and reload the counter.
REQ-023 APPLY: npc_type_out and comm_type_out SHALL take the latched values and v_lev_out SHALL stay 1.
  - The counter SHALL count down.
  - At count 0 the FSM SHALL go to RUN, or to IDLE if the latched npc_type is NoOut.
  - done SHALL pulse on the cycle the new state is entered.
REQ-024 Each hold state SHALL last exactly max(cfg_t_blank, 1) cycles, so the total accept-to-done latency is 3*max(cfg_t_blank, 1) + 1 cycles.
REQ-025 busy SHALL be 1 in ZERO_HOLD, BLANK and APPLY, and 0 otherwise.
REQ-026 In RUN, v_lev_out SHALL equal v_lev_in registered by one cycle, except that an input value of 3 SHALL be output as 1 and SHALL set fault.
REQ-027 In IDLE, v_lev_out SHALL be 1 and npc_type_out SHALL be NoOut.
REQ-028 All outputs SHALL be registered, with no combinational input-to-output path except cfg_ready, which is decoded from state.
REQ-029 The counter SHALL NOT wrap: cfg_t_blank = 0 SHALL behave as 1, and the all-ones value SHALL be held for the full 2^TDELAY_WIDTH - 1 cycles.
REQ-030 fault SHALL clear only on rst.

Reset
REQ-031 While rst = 1 the outputs SHALL be:
  - state IDLE, v_lev_out = 1, npc_type_out = 0, comm_type_out = 0;
  - busy = 0, done = 0, fault = 0, counter = 0.
REQ-032 Assertion of rst SHALL take effect without a clock edge, including in the middle of a sequence, and SHALL discard any latched request.
REQ-033 After rst deasserts, cfg_ready SHALL be 1 on the first clock edge.

Verification
REQ-034 Reset then request NPC, comm 0, t_blank 4 -> 4 cycles zero, 4 cycles NoOut, 4 cycles NPC with v_lev 1, done pulse at cycle 13, state RUN.
REQ-035 In RUN as NPC, v_lev_in sequence 0,2,1,3 -> v_lev_out 0,2,1,1 one cycle later, and fault = 1 from the cycle after the 3.
REQ-036 In RUN as NPC, request NPC with the same comm type -> no blanking, done on the next cycle, busy stays 0.
REQ-037 Request ANPC with t_blank 0 -> each phase lasts 1 cycle and done comes 4 cycles after acceptance; cfg_valid held during busy is ignored (no second sequence).
REQ-038 rst pulse during BLANK -> npc_type_out 0, v_lev_out 1, busy 0 immediately; the next request runs a full sequence.
REQ-039 From ANPC, request NoOut, t_blank 2 -> 6 cycles of blanking, then IDLE with done pulse, npc_type_out 0, v_lev_out 1.
